muldiv_iter: RTL and testbench



---
 rtl/muldiv_iter.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_iter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply, restoring divide, MTHI/MTLO.
// Optional MULDIV_FAST_MUL_EN: single-cycle array multiply for MULT/MULTU.
module muldiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        is_div_q;
    logic        sgn_a_q, sgn_b_q;
    logic [31:0] a_q, b_q;
    logic [63:0] acc;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // acc = {partial product high, remaining multiplier bits}; one multiplier bit per step
    function automatic logic [63:0] mul_step(input logic [63:0] acc_in, input logic [31:0] mcand);
        logic [32:0] sum;
        sum = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, mcand} : 33'd0);
        return {sum, acc_in[31:1]};
    endfunction

    // acc = {partial remainder, dividend bits shifting into quotient bits}
    function automatic logic [63:0] div_step(input logic [63:0] acc_in, input logic [31:0] divisor);
        logic [32:0] rem_sh;
        logic [32:0] trial;
        rem_sh = {acc_in[63:32], acc_in[31]};
        trial  = rem_sh - {1'b0, divisor};
        if (trial[32])
            return {rem_sh[31:0], acc_in[30:0], 1'b0};
        else
            return {trial[31:0], acc_in[30:0], 1'b1};
    endfunction

    logic        cmd_ok, is_mul_cmd, is_div_cmd, is_sgn_cmd;
    logic        sa_in, sb_in;
    logic [31:0] a_mag, b_mag;

    assign cmd_ok     = start && !flush;
    assign is_mul_cmd = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_cmd = (op == OP_DIV) || (op == OP_DIVU);
    assign is_sgn_cmd = (op == OP_MULT) || (op == OP_DIV);
    assign sa_in      = is_sgn_cmd && a[31];
    assign sb_in      = is_sgn_cmd && b[31];
    assign a_mag      = sa_in ? neg32(a) : a;
    assign b_mag      = sb_in ? neg32(b) : b;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] mag_prod, fast_prod;
    assign mag_prod  = {32'd0, a_mag} * {32'd0, b_mag};
    assign fast_prod = (sa_in ^ sb_in) ? neg64(mag_prod) : mag_prod;
`endif

    // Sign correction and special cases applied in FIX
    logic signed [63:0] prod_fix;
    logic        [31:0] quot_fix, rem_fix, a_raw;
    logic        [31:0] res_hi, res_lo;

    always_comb begin
        prod_fix = (sgn_a_q ^ sgn_b_q) ? neg64(acc) : acc;
        quot_fix = (sgn_a_q ^ sgn_b_q) ? neg32(acc[31:0]) : acc[31:0];
        rem_fix  = sgn_a_q ? neg32(acc[63:32]) : acc[63:32];
        a_raw    = sgn_a_q ? neg32(a_q) : a_q;
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (is_div_q) begin
            if (b_q == 32'd0) begin
                res_hi = a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quot_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_ok && (is_mul_cmd || is_div_cmd)) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nx = is_mul_cmd ? FIX : RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                if (flush)
                    state_nx = IDLE;
                else if (cnt == 5'd31)
                    state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 5'd0;
            is_div_q <= 1'b0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc      <= 64'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ok) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (is_mul_cmd || is_div_cmd) begin
                            cnt      <= 5'd0;
                            is_div_q <= is_div_cmd;
                            sgn_a_q  <= sa_in;
                            sgn_b_q  <= sb_in;
                            a_q      <= a_mag;
                            b_q      <= b_mag;
                            acc      <= {32'd0, is_div_cmd ? a_mag : b_mag};
`ifdef MULDIV_FAST_MUL_EN
                            // Product already sign-corrected; clear flags so FIX passes it through
                            if (is_mul_cmd) begin
                                acc     <= fast_prod;
                                sgn_a_q <= 1'b0;
                                sgn_b_q <= 1'b0;
                            end
`endif
                        end
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc <= is_div_q ? div_step(acc, b_q) : mul_step(acc, a_q);
                        cnt <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: literal and model-derived HI/LO results, latency, flush and reset.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        int     q, r;
        case (o)
            3'd1: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            3'd2: return {32'd0, x} * {32'd0, y};
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            3'd4: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
        return (o == 3'd1 || o == 3'd2) ? 1 : 33;
`else
        return (o == 3'd1 || o == 3'd2) ? 33 : 33;
`endif
    endfunction

    // Called at a negedge; returns at the first negedge after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int          n    = 0;
        bit          seen = 1'b0;
        logic [63:0] e;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(n), 64'(lat));
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (seen) chk({tag, " hilo"}, {hi, lo}, e);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp);
        sb_q.push_back(exp);
        issue(o, x, y);
        wait_done(tag, lat_of(o));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] old;
        logic [31:0] old_hi;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        bit          seen;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
        run("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run("div_neg",   3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divu_zero", 3'd4, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run("div_zero_s", 3'd3, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF);

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = 3'd5; a = 32'hA5A5_A5A5;
        @(posedge clk); @(negedge clk);
        chk("mthi hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mthi busy", 64'(busy), 64'd0);
        op = 3'd6; a = 32'h5A5A_5A5A;
        @(posedge clk); @(negedge clk);
        chk("mtlo lo", 64'(lo), 64'h5A5A_5A5A);
        chk("mtlo busy", 64'(busy), 64'd0);
        start = 1'b0; op = 3'd0;

        // MTLO offered while a divide is busy must be ignored
        sb_q.push_back({32'd2, 32'd14});
        issue(3'd3, 32'd100, 32'd7);
        start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_done("mtlo_ignored", 30);

        // flush in IDLE suppresses MTHI
        old_hi = hi;
        start = 1'b1; op = 3'd5; a = 32'h0000_1234; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; op = 3'd0; flush = 1'b0;
        chk("idle_flush hi", 64'(hi), 64'(old_hi));

        // flush in RUN cycle 10
        old = {hi, lo};
        issue(3'd3, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("run_flush busy", 64'(busy), 64'd0);
        chk("run_flush done", 64'(done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("run_flush no_done", 64'(seen), 64'd0);
        chk("run_flush hilo", {hi, lo}, old);

        // back-to-back model-checked operations
        for (int i = 0; i < 10; i++) begin
            ro = 3'(1 + $urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 50));
                2:       rb = -32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            run("rand", ro, ra, rb, model(ro, ra, rb));
        end

        run("pre_rst", 3'd2, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        // asynchronous reset in RUN cycle 5
        issue(3'd3, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst done", 64'(done), 64'd0);
        chk("async_rst hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("post_rst", 3'd1, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
